// File: rtl/mbr_sx_load.sv
// Load aligner: issues a word-aligned read, waits for the response under a watchdog,
// and returns the addressed byte/halfword/word sign- or zero-extended to 32 bits.
module mbr_sx_load #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_start,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_size,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic        ld_busy,
   output logic        ld_done,
   output logic [31:0] ld_data,
   output logic        ld_fault,
   output logic [1:0]  ld_fault_code
);

   // state | meaning
   // IDLE  | waiting for ld_start; request checked on capture
   // WAIT  | read outstanding, watchdog counting cycles without mem_rvalid
   // DONE  | one-cycle ld_done pulse, then back to IDLE
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT);

   state_t           state;
   logic [31:0]      addr_q;
   logic [2:0]       size_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             req_fault;
   logic [1:0]       req_code;

   function automatic logic [31:0] extract(input logic [31:0] rdata,
                                           input logic [1:0]  a,
                                           input logic [2:0]  sz);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = rdata[{a, 3'b000} +: 8];
      h = a[1] ? rdata[31:16] : rdata[15:0];
      case (sz[2:1])
         2'b00:   r = sz[0] ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   r = sz[0] ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

   // Illegal size outranks misalignment, which outranks the upper-half address check.
   always_comb begin
      req_fault = 1'b0;
      req_code  = 2'b00;
      if (ld_size > 3'b100) begin
         req_fault = 1'b1;
         req_code  = 2'b10;
      end else if ((ld_size[2:1] == 2'b01 && ld_addr[0]) ||
                   (ld_size == 3'b100 && ld_addr[1:0] != 2'b00)) begin
         req_fault = 1'b1;
         req_code  = 2'b01;
      end else if (ld_addr[31]) begin
         req_fault = 1'b1;
         req_code  = 2'b10;
      end
   end

   assign cnt_inc  = cnt + CNT_W'(1);
   assign ld_busy  = (state != IDLE);
   assign mem_addr = (state == WAIT) ? {addr_q[31:2], 2'b00} : 32'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         addr_q        <= 32'd0;
         size_q        <= 3'd0;
         cnt           <= '0;
         mem_req       <= 1'b0;
         ld_done       <= 1'b0;
         ld_data       <= 32'd0;
         ld_fault      <= 1'b0;
         ld_fault_code <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (ld_start) begin
                  addr_q <= ld_addr;
                  size_q <= ld_size;
                  if (req_fault) begin
                     state         <= DONE;
                     ld_done       <= 1'b1;
                     ld_data       <= 32'd0;
                     ld_fault      <= 1'b1;
                     ld_fault_code <= req_code;
                  end else begin
                     state   <= WAIT;
                     mem_req <= 1'b1;
                     cnt     <= '0;
                  end
               end
            end
            WAIT: begin
               // Data arriving on the terminal-count cycle still completes the load.
               if (mem_rvalid) begin
                  state         <= DONE;
                  mem_req       <= 1'b0;
                  ld_done       <= 1'b1;
                  ld_data       <= extract(mem_rdata, addr_q[1:0], size_q);
                  ld_fault      <= 1'b0;
                  ld_fault_code <= 2'b00;
               end else if (cnt_inc == TC) begin
                  state         <= DONE;
                  mem_req       <= 1'b0;
                  ld_done       <= 1'b1;
                  ld_data       <= 32'd0;
                  ld_fault      <= 1'b1;
                  ld_fault_code <= 2'b11;
                  cnt           <= cnt_inc;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            DONE: begin
               state   <= IDLE;
               ld_done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mbr_sx_load.sv
// Scoreboard bench for mbr_sx_load: expected completions are queued at issue and
// checked by a monitor on every ld_done; scenario tasks check timing and handshakes.
module tb_mbr_sx_load;

   typedef struct packed {
      logic [31:0] data;
      logic        fault;
      logic [1:0]  code;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_start = 1'b0;
   logic [31:0] ld_addr = 32'd0;
   logic [2:0]  ld_size = 3'd0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        ld_busy;
   logic        ld_done;
   logic [31:0] ld_data;
   logic        ld_fault;
   logic [1:0]  ld_fault_code;

   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   mbr_sx_load #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_addr(ld_addr),
      .ld_size(ld_size), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .ld_busy(ld_busy), .ld_done(ld_done),
      .ld_data(ld_data), .ld_fault(ld_fault), .ld_fault_code(ld_fault_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && ld_done) begin
         exp_t e;
         done_cnt++;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: ld_done=1 with no load outstanding, data=%h", ld_data);
         end else begin
            e = sb.pop_front();
            if ({ld_data, ld_fault, ld_fault_code} !== e) begin
               bad++;
               $display("FAIL done_result: got data=%h fault=%b code=%b, want data=%h fault=%b code=%b",
                        ld_data, ld_fault, ld_fault_code, e.data, e.fault, e.code);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Drives one load; mem_rvalid is pulsed in cycle T+k (k=0: never). Returns cycles to
   // ld_done, cycles with mem_req high and the last mem_addr seen, then steps into IDLE.
   task automatic run_load(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] rdata, input int k,
                           output int lat, output int req_cycles, output logic [31:0] addr_seen);
      ld_addr = addr;
      ld_size = size;
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      lat = 1;
      req_cycles = 0;
      addr_seen = 32'hxxxx_xxxx;
      while (!ld_done && lat < 600) begin
         if (mem_req) begin
            req_cycles++;
            addr_seen = mem_addr;
         end
         mem_rvalid = (lat == k);
         mem_rdata = (lat == k) ? rdata : 32'hDEAD_BEEF;
         step();
         lat++;
      end
      mem_rvalid = 1'b0;
      step();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step();
      step();
      total++;
      if ({mem_req, mem_addr, ld_busy, ld_done, ld_data, ld_fault, ld_fault_code} !== 70'd0) begin
         bad++;
         $display("FAIL reset_outputs: req=%b addr=%h busy=%b done=%b data=%h fault=%b code=%b, want all 0",
                  mem_req, mem_addr, ld_busy, ld_done, ld_data, ld_fault, ld_fault_code);
      end
      rst_n = 1'b1;
      step();
      total++;
      if (ld_busy !== 1'b0 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_idle: busy=%b req=%b, want 0 0", ld_busy, mem_req);
      end
   endtask

   task automatic test_lb;
      int lat, rc;
      logic [31:0] a;
      sb.push_back('{32'hFFFF_FF80, 1'b0, 2'b00});
      run_load(32'h0000_0003, 3'b000, 32'h80AB_CDEF, 2, lat, rc, a);
      total++;
      if (lat !== 3) begin bad++; $display("FAIL lb_latency: got %0d, want 3", lat); end
      total++;
      if (a !== 32'h0000_0000 || rc !== 2) begin
         bad++; $display("FAIL lb_mem_addr: got addr=%h req_cycles=%0d, want 00000000 2", a, rc);
      end
      sb.push_back('{32'h0000_00CD, 1'b0, 2'b00});
      run_load(32'h0000_0005, 3'b001, 32'h80AB_CDEF, 1, lat, rc, a);
      total++;
      if (lat !== 2 || a !== 32'h0000_0004) begin
         bad++; $display("FAIL lbu_lane1: got lat=%0d addr=%h, want 2 00000004", lat, a);
      end
   endtask

   task automatic test_lh;
      int lat, rc;
      logic [31:0] a;
      sb.push_back('{32'h0000_9234, 1'b0, 2'b00});
      run_load(32'h0000_1002, 3'b011, 32'h9234_5678, 1, lat, rc, a);
      total++;
      if (a !== 32'h0000_1000) begin bad++; $display("FAIL lhu_mem_addr: got %h, want 00001000", a); end
      sb.push_back('{32'hFFFF_9234, 1'b0, 2'b00});
      run_load(32'h0000_1002, 3'b010, 32'h9234_5678, 3, lat, rc, a);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL lh_latency: got %0d, want 4", lat); end
      sb.push_back('{32'h0000_5678, 1'b0, 2'b00});
      run_load(32'h0000_1000, 3'b010, 32'h9234_5678, 1, lat, rc, a);
   endtask

   task automatic test_faults;
      int lat, rc;
      logic [31:0] a;
      sb.push_back('{32'd0, 1'b1, 2'b01});
      run_load(32'h0000_0006, 3'b100, 32'h1111_1111, 1, lat, rc, a);
      total++;
      if (lat !== 1 || rc !== 0) begin
         bad++; $display("FAIL misaligned_lw: got lat=%0d req_cycles=%0d, want 1 0", lat, rc);
      end
      sb.push_back('{32'd0, 1'b1, 2'b10});
      run_load(32'h8000_0000, 3'b000, 32'h1111_1111, 1, lat, rc, a);
      total++;
      if (lat !== 1 || rc !== 0) begin
         bad++; $display("FAIL upper_addr_lb: got lat=%0d req_cycles=%0d, want 1 0", lat, rc);
      end
      sb.push_back('{32'd0, 1'b1, 2'b10});
      run_load(32'h0000_0000, 3'b101, 32'h1111_1111, 1, lat, rc, a);
      total++;
      if (lat !== 1 || rc !== 0) begin
         bad++; $display("FAIL illegal_size: got lat=%0d req_cycles=%0d, want 1 0", lat, rc);
      end
      // Illegal size outranks misalignment; misalignment outranks the upper-half check.
      sb.push_back('{32'd0, 1'b1, 2'b10});
      run_load(32'h0000_0001, 3'b111, 32'h1111_1111, 1, lat, rc, a);
      sb.push_back('{32'd0, 1'b1, 2'b01});
      run_load(32'h8000_0001, 3'b011, 32'h1111_1111, 1, lat, rc, a);
   endtask

   task automatic test_timeout;
      int lat, rc, d0;
      logic [31:0] a;
      sb.push_back('{32'd0, 1'b1, 2'b11});
      run_load(32'h0000_0010, 3'b100, 32'h0, 0, lat, rc, a);
      total++;
      if (rc !== 4 || lat !== 5) begin
         bad++; $display("FAIL timeout_window: got req_cycles=%0d lat=%0d, want 4 5", rc, lat);
      end
      d0 = done_cnt;
      mem_rvalid = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      step();
      mem_rvalid = 1'b0;
      total++;
      if (ld_busy !== 1'b0 || mem_req !== 1'b0) begin
         bad++; $display("FAIL late_rvalid_idle: busy=%b req=%b, want 0 0", ld_busy, mem_req);
      end
      step();
      total++;
      if (done_cnt !== d0) begin
         bad++; $display("FAIL late_rvalid_done: got %0d extra ld_done, want 0", done_cnt - d0);
      end
      // rvalid on the terminal-count cycle: data wins
      sb.push_back('{32'h0BAD_F00D, 1'b0, 2'b00});
      run_load(32'h0000_0014, 3'b100, 32'h0BAD_F00D, 4, lat, rc, a);
      total++;
      if (lat !== 5) begin bad++; $display("FAIL tc_data_wins_latency: got %0d, want 5", lat); end
   endtask

   task automatic test_ignore_start;
      int d0;
      d0 = done_cnt;
      sb.push_back('{32'hCAFE_F00D, 1'b0, 2'b00});
      ld_addr = 32'h0000_0040;
      ld_size = 3'b100;
      ld_start = 1'b1;
      step();
      ld_addr = 32'h0000_0045;
      ld_size = 3'b000;
      step();
      ld_start = 1'b0;
      total++;
      if (mem_addr !== 32'h0000_0040 || mem_req !== 1'b1) begin
         bad++; $display("FAIL start_in_wait: got addr=%h req=%b, want 00000040 1", mem_addr, mem_req);
      end
      mem_rvalid = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      step();
      mem_rvalid = 1'b0;
      ld_addr = 32'h0000_0048;
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      total++;
      if (ld_busy !== 1'b0 || mem_req !== 1'b0) begin
         bad++; $display("FAIL start_in_done: busy=%b req=%b, want 0 0", ld_busy, mem_req);
      end
      step();
      step();
      total++;
      if (done_cnt - d0 !== 1) begin
         bad++; $display("FAIL single_done: got %0d ld_done pulses, want 1", done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back;
      int lat1, lat2, rc;
      logic [31:0] a1, a2;
      sb.push_back('{32'h0102_0304, 1'b0, 2'b00});
      run_load(32'h0000_0100, 3'b100, 32'h0102_0304, 1, lat1, rc, a1);
      sb.push_back('{32'hF0E0_D0C0, 1'b0, 2'b00});
      run_load(32'h0000_0104, 3'b100, 32'hF0E0_D0C0, 2, lat2, rc, a2);
      total++;
      if (lat1 !== 2 || lat2 !== 3 || a2 !== 32'h0000_0104) begin
         bad++; $display("FAIL back_to_back: got lat=%0d,%0d addr2=%h, want 2,3 00000104", lat1, lat2, a2);
      end
   endtask

   task automatic test_reset_mid_wait;
      int d0, lat, rc;
      logic [31:0] a;
      d0 = done_cnt;
      ld_addr = 32'h0000_0020;
      ld_size = 3'b100;
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0 || ld_busy !== 1'b0 || ld_data !== 32'd0 || mem_addr !== 32'd0) begin
         bad++; $display("FAIL reset_mid_wait: req=%b busy=%b data=%h addr=%h, want 0 0 0 0",
                         mem_req, ld_busy, ld_data, mem_addr);
      end
      step();
      rst_n = 1'b1;
      step();
      step();
      total++;
      if (done_cnt !== d0) begin bad++; $display("FAIL reset_no_done: got %0d ld_done, want 0", done_cnt - d0); end
      sb.push_back('{32'h1234_5678, 1'b0, 2'b00});
      run_load(32'h0000_0020, 3'b100, 32'h1234_5678, 1, lat, rc, a);
      total++;
      if (lat !== 2 || a !== 32'h0000_0020) begin
         bad++; $display("FAIL post_reset_lw: got lat=%0d addr=%h, want 2 00000020", lat, a);
      end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_lh();
      test_faults();
      test_timeout();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_wait();
      step();
      total++;
      if (sb.size() !== 0) begin
         bad++; $display("FAIL scoreboard_drain: %0d expected completions never seen, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
